// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter between instruction fetch (IF) and data memory (DM).
// Optional fetch starvation guard enabled with `MEM_ARB_STARVE_GUARD_EN.
//
// state | meaning
// IDLE  | no access in flight; arbitrate pending requests
// ISSUE | mem_en high for one cycle with the granted access on mem_*
// RESP  | read data returned on *_rdata with *_rvalid; arbitrate again
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  own_q, own_d;
  logic                  if_gnt_q, if_gnt_d;
  logic                  dm_gnt_q, dm_gnt_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic                  dm_rvalid_q, dm_rvalid_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] if_hold_q, if_hold_d;
  logic [DATA_WIDTH-1:0] dm_hold_q, dm_hold_d;
  logic                  force_if;
  logic                  grant_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= 4'd0;
    end else if (if_gnt_d) begin
      starve_q <= 4'd0;
    end else if (dm_gnt_d && if_req) begin
      starve_q <= starve_q + 4'd1;
    end
  end

  assign force_if = if_req && (starve_q == 4'(STARVE_LIMIT));
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^4'(STARVE_LIMIT);
  assign force_if = 1'b0;
`endif

  assign grant_if = if_req && (!dm_req || force_if);

  always_comb begin
    state_d     = state_q;
    own_d       = own_q;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_hold_d   = if_hold_q;
    dm_hold_d   = dm_hold_q;

    case (state_q)
      ISSUE: begin
        if (mem_we_q) begin
          state_d = IDLE;
        end else begin
          state_d     = RESP;
          if_rvalid_d = !own_q;
          dm_rvalid_d = own_q;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (own_q) dm_hold_d = mem_rdata;
        else       if_hold_d = mem_rdata;
      end
      default: state_d = IDLE;
    endcase

    if ((state_q != ISSUE) && (if_req || dm_req)) begin
      state_d  = ISSUE;
      mem_en_d = 1'b1;
      if (grant_if) begin
        own_d      = 1'b0;
        if_gnt_d   = 1'b1;
        mem_we_d   = 1'b0;
        mem_addr_d = if_addr;
      end else begin
        own_d       = 1'b1;
        dm_gnt_d    = 1'b1;
        mem_we_d    = dm_we;
        mem_addr_d  = dm_addr;
        mem_wdata_d = dm_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      own_q       <= 1'b0;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_hold_q   <= '0;
      dm_hold_q   <= '0;
    end else begin
      state_q     <= state_d;
      own_q       <= own_d;
      if_gnt_q    <= if_gnt_d;
      dm_gnt_q    <= dm_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_hold_q   <= if_hold_d;
      dm_hold_q   <= dm_hold_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign dm_gnt    = dm_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign dm_rvalid = dm_rvalid_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Memory data arrives in the RESP cycle itself, so it is forwarded during
  // the rvalid pulse and held from the captured copy afterwards.
  assign if_rdata = if_rvalid_q ? mem_rdata : if_hold_q;
  assign dm_rdata = dm_rvalid_q ? mem_rdata : dm_hold_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a one-cycle-latency memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  int total = 0;
  int bad = 0;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  always @(posedge clk) if (mem_en && !mem_we) mem_rdata <= mem_word(mem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++; if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000000", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we}); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
    total++; if (if_rdata !== 32'h0) begin bad++; $display("FAIL reset_if_rdata: got %h want 0", if_rdata); end
    total++; if (dm_rdata !== 32'h0) begin bad++; $display("FAIL reset_dm_rdata: got %h want 0", dm_rdata); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_if_read();
    if_req = 1'b1; if_addr = 32'h40;
    tick();
    total++; if ({if_gnt, dm_gnt, mem_en, mem_we} !== 4'b1010) begin
      bad++; $display("FAIL ifrd_c1_ctrl: got %b want 1010", {if_gnt, dm_gnt, mem_en, mem_we}); end
    total++; if (mem_addr !== 32'h40) begin bad++; $display("FAIL ifrd_c1_addr: got %h want 40", mem_addr); end
    if_req = 1'b0;
    tick();
    total++; if ({if_rvalid, dm_rvalid, mem_en} !== 3'b100) begin
      bad++; $display("FAIL ifrd_c2_ctrl: got %b want 100", {if_rvalid, dm_rvalid, mem_en}); end
    total++; if (if_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL ifrd_c2_data: got %h want deadbeef", if_rdata); end
    tick();
    total++; if (if_rvalid !== 1'b0) begin bad++; $display("FAIL ifrd_c3_rvalid: got %b want 0", if_rvalid); end
    total++; if (if_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL ifrd_c3_hold: got %h want deadbeef", if_rdata); end
  endtask

  task automatic test_dm_write();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'h12345678;
    tick();
    total++; if ({dm_gnt, if_gnt, mem_en, mem_we} !== 4'b1011) begin
      bad++; $display("FAIL dmwr_c1_ctrl: got %b want 1011", {dm_gnt, if_gnt, mem_en, mem_we}); end
    total++; if (mem_addr !== 32'h100 || mem_wdata !== 32'h12345678) begin
      bad++; $display("FAIL dmwr_c1_bus: got %h/%h want 100/12345678", mem_addr, mem_wdata); end
    dm_req = 1'b0; dm_we = 1'b0;
    tick();
    total++; if ({dm_rvalid, if_rvalid, mem_en, mem_we} !== 4'b0001) begin
      bad++; $display("FAIL dmwr_c2_ctrl: got %b want 0001", {dm_rvalid, if_rvalid, mem_en, mem_we}); end
    total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL dmwr_c2_hold: got %h want 100", mem_addr); end
    if_req = 1'b1; if_addr = 32'h44;
    tick();
    total++; if ({if_gnt, mem_en, mem_we} !== 3'b110) begin
      bad++; $display("FAIL dmwr_c3_idle_gnt: got %b want 110", {if_gnt, mem_en, mem_we}); end
    if_req = 1'b0;
    tick();
    total++; if ({if_rvalid, dm_rvalid} !== 2'b10 || if_rdata !== mem_word(32'h44)) begin
      bad++; $display("FAIL dmwr_c4_rd: got %b/%h want 10/%h", {if_rvalid, dm_rvalid}, if_rdata, mem_word(32'h44)); end
    tick();
  endtask

  task automatic test_contention();
    if_req = 1'b1; if_addr = 32'h80;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    tick();
    total++; if ({dm_gnt, if_gnt} !== 2'b10 || mem_addr !== 32'h200) begin
      bad++; $display("FAIL cont_c1: got %b/%h want 10/200", {dm_gnt, if_gnt}, mem_addr); end
    dm_req = 1'b0;
    tick();
    total++; if ({dm_rvalid, if_rvalid, if_gnt} !== 3'b100 || dm_rdata !== mem_word(32'h200)) begin
      bad++; $display("FAIL cont_c2: got %b/%h want 100/%h", {dm_rvalid, if_rvalid, if_gnt}, dm_rdata, mem_word(32'h200)); end
    tick();
    total++; if ({if_gnt, dm_gnt} !== 2'b10 || mem_addr !== 32'h80) begin
      bad++; $display("FAIL cont_c3: got %b/%h want 10/80", {if_gnt, dm_gnt}, mem_addr); end
    if_req = 1'b0;
    tick();
    total++; if (if_rvalid !== 1'b1 || if_rdata !== mem_word(32'h80)) begin
      bad++; $display("FAIL cont_c4: got %b/%h want 1/%h", if_rvalid, if_rdata, mem_word(32'h80)); end
    total++; if (dm_rdata !== mem_word(32'h200)) begin
      bad++; $display("FAIL cont_c4_dm_hold: got %h want %h", dm_rdata, mem_word(32'h200)); end
    tick();
  endtask

  task automatic test_back_to_back();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h500; dm_wdata = 32'hA;
    tick();
    total++; if (dm_gnt !== 1'b1 || mem_addr !== 32'h500) begin
      bad++; $display("FAIL b2b_wr1: got %b/%h want 1/500", dm_gnt, mem_addr); end
    dm_addr = 32'h504; dm_wdata = 32'hB;
    tick();
    total++; if ({dm_gnt, mem_en} !== 2'b00) begin bad++; $display("FAIL b2b_wr_gap: got %b want 00", {dm_gnt, mem_en}); end
    tick();
    total++; if (dm_gnt !== 1'b1 || mem_addr !== 32'h504 || mem_wdata !== 32'hB) begin
      bad++; $display("FAIL b2b_wr2: got %b/%h/%h want 1/504/b", dm_gnt, mem_addr, mem_wdata); end
    dm_we = 1'b0; dm_addr = 32'h600;
    tick();
    tick();
    total++; if (dm_gnt !== 1'b1 || mem_addr !== 32'h600 || mem_we !== 1'b0) begin
      bad++; $display("FAIL b2b_rd1: got %b/%h/%b want 1/600/0", dm_gnt, mem_addr, mem_we); end
    dm_addr = 32'h604;
    tick();
    total++; if (dm_rvalid !== 1'b1 || dm_rdata !== mem_word(32'h600)) begin
      bad++; $display("FAIL b2b_rd1_resp: got %b/%h want 1/%h", dm_rvalid, dm_rdata, mem_word(32'h600)); end
    tick();
    total++; if (dm_gnt !== 1'b1 || mem_addr !== 32'h604) begin
      bad++; $display("FAIL b2b_rd2: got %b/%h want 1/604", dm_gnt, mem_addr); end
    dm_req = 1'b0;
    tick();
    total++; if (dm_rvalid !== 1'b1 || dm_rdata !== mem_word(32'h604)) begin
      bad++; $display("FAIL b2b_rd2_resp: got %b/%h want 1/%h", dm_rvalid, dm_rdata, mem_word(32'h604)); end
    tick();
  endtask

  task automatic test_starvation();
    int grants = 0;
    int if_at = 0;
    int both = 0;
    int exp_if_at;
    logic seen;
`ifdef MEM_ARB_STARVE_GUARD_EN
    exp_if_at = 5;
`else
    exp_if_at = 0;
`endif
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h700;
    if_req = 1'b1; if_addr = 32'h300;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (dm_gnt && if_gnt) both++;
      if (dm_gnt) begin grants++; dm_addr = dm_addr + 32'd4; end
      if (if_gnt) begin
        grants++;
        if (if_at == 0) if_at = grants;
        if_req = 1'b0;
      end
    end
    dm_req = 1'b0;
    total++; if (if_at != exp_if_at) begin bad++; $display("FAIL starve_if_slot: got %0d want %0d", if_at, exp_if_at); end
    total++; if (grants != 12) begin bad++; $display("FAIL starve_grants: got %0d want 12", grants); end
    total++; if (both != 0) begin bad++; $display("FAIL starve_dual_gnt: got %0d want 0", both); end
    if (if_req) begin
      seen = 1'b0;
      for (int i = 0; i < 6 && !seen; i++) begin
        tick();
        if (if_gnt) seen = 1'b1;
      end
      if_req = 1'b0;
      total++; if (seen !== 1'b1) begin bad++; $display("FAIL starve_drain: got %b want 1", seen); end
    end
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset_mid_read();
    if_req = 1'b1; if_addr = 32'h44;
    tick();
    total++; if ({if_gnt, mem_en} !== 2'b11) begin bad++; $display("FAIL rstmid_issue: got %b want 11", {if_gnt, mem_en}); end
    if_req = 1'b0;
    reset = 1'b1;
    tick();
    total++; if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we} !== 6'b0) begin
      bad++; $display("FAIL rstmid_ctrl: got %b want 000000", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we}); end
    total++; if (mem_addr !== 32'h0 || if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
      bad++; $display("FAIL rstmid_data: got %h/%h/%h want 0/0/0", mem_addr, if_rdata, dm_rdata); end
    reset = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h800;
    tick();
    total++; if ({dm_gnt, if_rvalid, mem_en} !== 3'b101) begin
      bad++; $display("FAIL rstmid_new_gnt: got %b want 101", {dm_gnt, if_rvalid, mem_en}); end
    dm_req = 1'b0;
    tick();
    total++; if (dm_rvalid !== 1'b1 || if_rvalid !== 1'b0 || dm_rdata !== mem_word(32'h800)) begin
      bad++; $display("FAIL rstmid_new_resp: got %b/%b/%h want 1/0/%h", dm_rvalid, if_rvalid, dm_rdata, mem_word(32'h800)); end
    tick();
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_dm_write();
    test_contention();
    test_back_to_back();
    test_starvation();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single shared synchronous memory port between the instruction-fetch requester (IF) and the memory-stage data requester (DM) of the pipelined core. It serialises accesses with a small state machine, drives the memory port from registers, and returns read data with a per-requester valid pulse. Data accesses have priority; an optional starvation guard bounds how long fetch can be locked out.

## Interface
- ADDR_WIDTH, 32, byte address width of both requesters and the memory port
- DATA_WIDTH, 32, data width
- STARVE_LIMIT, 4, consecutive DM grants allowed while IF waits (guard only; range 1..15)

- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_WIDTH  fetch address
- if_gnt  out  1  one-cycle pulse; fetch request accepted
- if_rvalid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_WIDTH  fetched word
- dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata until dm_gnt
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  store data
- dm_gnt  out  1  one-cycle pulse; data request accepted
- dm_rvalid  out  1  one-cycle pulse; dm_rdata valid (reads only)
- dm_rdata  out  DATA_WIDTH  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after mem_en with mem_we=0

## Operation
- States: IDLE, ISSUE, RESP. Owner register `own` (0 = IF, 1 = DM) is captured on each grant.
- Arbitration happens in IDLE and RESP. If any request is pending, the block selects a winner, registers the winner's address, write enable and data onto the mem_* outputs, pulses the matching *_gnt, and moves to ISSUE. Otherwise it goes to IDLE.
- Priority: DM wins when both requesters are pending, except when the starvation guard forces IF.
- ISSUE: mem_en=1 for exactly this cycle.
  - Read: go to RESP.
  - Write: go to IDLE. No rvalid is produced; the write completes at this edge.
- RESP: mem_rdata is registered into if_rdata or dm_rdata according to `own`, and the matching *_rvalid is pulsed. The block arbitrates again in the same cycle.
- Only one access is outstanding at a time. Requests that arrive while the block is in ISSUE wait.
- *_rdata holds its last value between rvalid pulses.
- mem_we, mem_addr and mem_wdata hold their values outside ISSUE. mem_en is 0 outside ISSUE.
- Address and data pass through unmodified; no width conversion and no alignment checks.

## Timing
- Reset (synchronous): state=IDLE, own=0, starve counter=0.
  - Outputs zero at the next edge: if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata.
- Request seen in cycle N (state IDLE):
  - gnt and mem_* outputs registered at the edge ending N, so they are visible in N+1 (ISSUE, mem_en=1).
  - For reads, rvalid and rdata are visible in N+2.
- Peak throughput is one read every 2 cycles (RESP→ISSUE) and one write every 2 cycles (ISSUE→IDLE→ISSUE).
- Dropping a request before its gnt is illegal.
- Simultaneous requests in the same cycle: exactly one gnt per arbitration; the loser stays pending.
- Reset asserted in ISSUE or RESP abandons the access: no rvalid is produced and mem_en is 0 after the edge.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - A 4-bit counter increments on every DM grant made while if_req=1, and clears on any IF grant.
  - When the counter equals STARVE_LIMIT and if_req=1, the next arbitration grants IF regardless of dm_req.
- Not defined: strict DM priority; the counter is not synthesised and IF may starve indefinitely.

## Test plan
- Single IF read: if_req=1, if_addr=0x40 at cycle 0; memory returns 0xDEADBEEF → if_gnt and mem_en with mem_addr=0x40 at cycle 1; if_rvalid with if_rdata=0xDEADBEEF at cycle 2.
- DM write: dm_req=1, dm_we=1, addr 0x100, wdata 0x12345678 → dm_gnt, mem_en=1, mem_we=1 at cycle 1; no dm_rvalid; state IDLE at cycle 2.
- Contention: if_req and dm_req (read) both asserted at cycle 0 → dm_gnt at cycle 1, dm_rvalid at cycle 2, if_gnt at cycle 3, if_rvalid at cycle 4.
- Starvation with the guard defined and STARVE_LIMIT=4: dm_req held continuously with back-to-back reads, if_req=1 → the 5th grant is if_gnt. Without the macro, if_gnt never occurs.
- Reset mid-read: reset asserted in the ISSUE cycle → no rvalid afterwards; all outputs 0; a new request is serviced with normal latency after reset drops.
